// File: rtl/pipeline_pkg.sv
// Shared pipeline types: data-memory request/response payloads and responder states.
package pipeline_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned BE_W   = 4;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            err;
    } dmem_rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module dmem_array
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             rd,
    input  logic [BE_W-1:0]  we,
    input  logic [IDX_W-1:0] idx,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (we[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Non-load accesses return zero so stores and errors read back as 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= rd ? mem[idx] : '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed wait states, held response.
module dmem_responder
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_in, acc_req;
    logic             load_req;
    logic             access_c;
    logic             in_range_c;
    logic             mem_en_c;

    always_comb begin
        req_in.we    = req_we;
        req_in.be    = req_be;
        req_in.addr  = req_addr;
        req_in.wdata = req_wdata;
    end

    // Next state; the access fires on the decision to enter RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_req = 1'b0;
        access_c = 1'b0;
        acc_req  = req_q;
        case (state_q)
            IDLE: begin
                if (req_ready && req_valid) begin
                    load_req = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d  = RESP;
                        access_c = 1'b1;
                        acc_req  = req_in;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end else begin
                    state_d  = RESP;
                    access_c = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_range_c = (32'(acc_req.addr) < 32'(DEPTH_WORDS));
    assign mem_en_c   = access_c && !reset;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (mem_en_c),
        .rd    (!acc_req.we && in_range_c),
        .we    ((acc_req.we && in_range_c) ? acc_req.be : BE_W'(0)),
        .idx   (IDX_W'(acc_req.addr)),
        .wdata (acc_req.wdata),
        .rdata (rsp_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == RESP);
            if (load_req) begin
                req_q <= req_in;
            end
            if (access_c) begin
                rsp_err <= !in_range_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance against a transaction model.
module tb_dmem_responder;
    import pipeline_pkg::*;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = 4'h0;
    logic [29:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b1;

    logic        ready_a, valid_a, err_a, ready_b, valid_b, err_b;
    logic [31:0] rdata_a, rdata_b;
    logic        s_ready, s_valid, s_err;
    logic [31:0] s_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !sel), .req_ready(ready_a),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(err_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel), .req_ready(ready_b),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(err_b)
    );

    assign s_ready = sel ? ready_b : ready_a;
    assign s_valid = sel ? valid_b : valid_a;
    assign s_err   = sel ? err_b   : err_a;
    assign s_rdata = sel ? rdata_b : rdata_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    logic [31:0] mmem [int];
    bit          m_ready [2] = '{0, 0};
    bit          m_valid [2] = '{0, 0};
    bit          m_err   [2] = '{0, 0};
    bit          m_known [2] = '{1, 1};
    logic [31:0] m_rdata [2] = '{0, 0};
    bit          m_pend  [2] = '{0, 0};
    bit          m_resp  [2] = '{0, 0};
    int          m_due   [2];
    bit          m_we    [2];
    logic [3:0]  m_be    [2];
    logic [29:0] m_addr  [2];
    logic [31:0] m_wd    [2];

    task automatic m_access(input int d, input bit we, input logic [3:0] be,
                            input logic [29:0] addr, input logic [31:0] wd);
        int key;
        logic [31:0] w;
        m_known[d] = 1'b1;
        m_rdata[d] = 32'h0;
        if (32'(addr) >= DEPTH) begin
            m_err[d] = 1'b1;
        end else begin
            m_err[d] = 1'b0;
            key = d * 4096 + int'(addr);
            if (we) begin
                if (mmem.exists(key)) begin
                    w = mmem[key];
                    for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = wd[i*8 +: 8];
                    mmem[key] = w;
                end else if (be == 4'hF) begin
                    mmem[key] = wd;
                end
            end else if (mmem.exists(key)) begin
                m_rdata[d] = mmem[key];
            end else begin
                m_known[d] = 1'b0;
            end
        end
        m_resp[d]  = 1'b1;
        m_pend[d]  = 1'b0;
        m_valid[d] = 1'b1;
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int ws;
            ws = (d == 0) ? 2 : 0;
            if (reset) begin
                m_ready[d] = 0; m_valid[d] = 0; m_err[d] = 0; m_rdata[d] = 0;
                m_known[d] = 1; m_pend[d] = 0; m_resp[d] = 0;
            end else if (m_resp[d]) begin
                if (rsp_ready) begin
                    m_resp[d] = 0; m_valid[d] = 0; m_ready[d] = 1;
                end
            end else if (m_pend[d]) begin
                if (cyc == m_due[d]) m_access(d, m_we[d], m_be[d], m_addr[d], m_wd[d]);
            end else if (m_ready[d]) begin
                if (req_valid && (int'(sel) == d)) begin
                    m_ready[d] = 0;
                    if (ws == 0) begin
                        m_access(d, req_we, req_be, req_addr, req_wdata);
                    end else begin
                        m_pend[d] = 1; m_due[d] = cyc + ws;
                        m_we[d] = req_we; m_be[d] = req_be; m_addr[d] = req_addr; m_wd[d] = req_wdata;
                    end
                end
            end else begin
                m_ready[d] = 1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.req_ready", 32'(ready_a), 32'(m_ready[0]));
            chk("a.rsp_valid", 32'(valid_a), 32'(m_valid[0]));
            chk("a.rsp_err",   32'(err_a),   32'(m_err[0]));
            if (m_known[0]) chk("a.rsp_rdata", rdata_a, m_rdata[0]);
            chk("b.req_ready", 32'(ready_b), 32'(m_ready[1]));
            chk("b.rsp_valid", 32'(valid_b), 32'(m_valid[1]));
            chk("b.rsp_err",   32'(err_b),   32'(m_err[1]));
            if (m_known[1]) chk("b.rsp_rdata", rdata_b, m_rdata[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic xact(input bit we, input logic [3:0] be, input logic [29:0] addr,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic e, output int lat);
        int n;
        n = 0;
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        if (!s_ready) chk("req_ready_timeout", 32'(s_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!s_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!s_valid) chk("rsp_timeout", 32'(s_valid), 32'd1);
        rd = s_rdata;
        e  = s_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = ~req_valid; req_we = 1'b1; req_be = 4'hF;
            req_addr = 30'h010; req_wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("hold_valid", 32'(s_valid), 32'd1);
            chk("hold_ready", 32'(s_ready), 32'd0);
            chk("hold_rdata", s_rdata, rd);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, cnt;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_rdata", s_rdata, 32'h0);
        chk("rst_err",   32'(s_err),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(s_ready), 32'd1);

        // full store then load
        xact(1, 4'hF, 30'h010, 32'hDEADBEEF, 0, rd, e, lat);
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_err", 32'(e), 32'd0);
        chk("st_rdata", rd, 32'h0);
        xact(0, 4'h0, 30'h010, 32'h0, 0, rd, e, lat);
        chk("ld_full", rd, 32'hDEADBEEF);

        // partial and empty byte enables
        xact(1, 4'b0010, 30'h010, 32'h0000AA00, 0, rd, e, lat);
        xact(0, 4'h0, 30'h010, 32'h0, 0, rd, e, lat);
        chk("ld_partial", rd, 32'hDEADAAEF);
        xact(1, 4'b0000, 30'h010, 32'h11111111, 0, rd, e, lat);
        chk("be0_lat", 32'(lat), 32'd3);
        xact(0, 4'h0, 30'h010, 32'h0, 0, rd, e, lat);
        chk("ld_be0", rd, 32'hDEADAAEF);

        // response held for 5 cycles
        xact(0, 4'h0, 30'h010, 32'h0, 5, rd, e, lat);
        chk("ld_held", rd, 32'hDEADAAEF);

        // out of range
        xact(1, 4'hF, 30'h000, 32'hA5A5A5A5, 0, rd, e, lat);
        xact(1, 4'hF, 30'h3FF, 32'h3FF3FF00, 0, rd, e, lat);
        xact(0, 4'h0, 30'd1024, 32'h0, 0, rd, e, lat);
        chk("oor_ld_err", 32'(e), 32'd1);
        chk("oor_ld_rdata", rd, 32'h0);
        xact(1, 4'hF, 30'd1024, 32'h0BADF00D, 0, rd, e, lat);
        chk("oor_st_err", 32'(e), 32'd1);
        xact(1, 4'hF, 30'h2000010, 32'h0BADF00D, 0, rd, e, lat);
        xact(0, 4'h0, 30'h000, 32'h0, 0, rd, e, lat);
        chk("oor_keep0", rd, 32'hA5A5A5A5);
        xact(0, 4'h0, 30'h010, 32'h0, 0, rd, e, lat);
        chk("oor_keep10", rd, 32'hDEADAAEF);
        xact(0, 4'h0, 30'h3FF, 32'h0, 0, rd, e, lat);
        chk("oor_keep3ff", rd, 32'h3FF3FF00);
        xact(0, 4'h0, 30'h010, 32'h0, 0, rd, e, lat);
        chk("in_range_err", 32'(e), 32'd0);

        // reset during WAIT drops the store
        xact(1, 4'hF, 30'h020, 32'hCAFEF00D, 0, rd, e, lat);
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 30'h020; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_valid) cnt++;
        end
        chk("wait_rst_no_rsp", 32'(cnt), 32'd0);
        xact(0, 4'h0, 30'h020, 32'h0, 0, rd, e, lat);
        chk("wait_rst_old", rd, 32'hCAFEF00D);

        // reset during RESP keeps the committed store
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 30'h030; req_wdata = 32'h55AA55AA;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("resp_pre_rst", 32'(s_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("resp_rst_drop", 32'(s_valid), 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        xact(0, 4'h0, 30'h030, 32'h0, 0, rd, e, lat);
        chk("resp_rst_kept", rd, 32'h55AA55AA);

        // zero wait states
        sel = 1'b1;
        @(negedge clk);
        xact(1, 4'hF, 30'h010, 32'h0F0F0F0F, 0, rd, e, lat);
        chk("ws0_st_lat", 32'(lat), 32'd1);
        xact(0, 4'h0, 30'h010, 32'h0, 0, rd, e, lat);
        chk("ws0_ld_lat", 32'(lat), 32'd1);
        chk("ws0_ld", rd, 32'h0F0F0F0F);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 30'h010; rsp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_valid) cnt++;
        end
        req_valid = 1'b0;
        chk("ws0_throughput", 32'(cnt), 32'd5);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
